memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-master memory arbiter. The CPU owns the bus by default. An external loader/DMA gets bounded
// bursts, and a guard cycle after each burst guarantees the CPU at least two enabled cycles between grants.
module memory_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [1:0]        cpu_ctrl_bus,
    input  logic [DATA_W-1:0] cpu_addr_bus,
    input  logic [DATA_W-1:0] cpu_write_bus,
    output logic [DATA_W-1:0] cpu_read_bus,
    output logic              cpu_enable,
    input  logic              ext_req,
    input  logic [1:0]        ext_ctrl,
    input  logic [DATA_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [1:0]        mem_ctrl,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Memory control encoding shared with the CPU and the memory.
    localparam logic [1:0] MEMORY_STAY  = 2'd0;
    localparam logic [1:0] MEMORY_READ  = 2'd1;
    localparam logic [1:0] MEMORY_WRITE = 2'd2;

    localparam logic [2:0] BURST_LAST = 3'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        EXT_OWN = 2'd1,
        GUARD   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            CPU_OWN: begin
                if (ext_req) begin
                    state_d     = EXT_OWN;
                    burst_cnt_d = 3'd0;
                end
            end
            EXT_OWN: begin
                // A dropped request always ends the grant, even if it would return next cycle.
                if (!ext_req) begin
                    state_d = GUARD;
                end else begin
                    burst_cnt_d = burst_cnt_q + 3'd1;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state_q     <= CPU_OWN;
            burst_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Bus steering is combinational. The CPU's access in the request cycle completes before the handover.
    always_comb begin
        mem_ctrl     = cpu_ctrl_bus;
        mem_addr     = cpu_addr_bus;
        mem_wdata    = cpu_write_bus;
        cpu_read_bus = mem_rdata;
        cpu_enable   = 1'b1;
        ext_gnt      = 1'b0;
        ext_rdata    = '0;
        if (state_q == EXT_OWN) begin
            mem_ctrl     = ext_req ? ext_ctrl : MEMORY_STAY;
            mem_addr     = ext_addr;
            mem_wdata    = ext_wdata;
            cpu_read_bus = '0;
            cpu_enable   = 1'b0;
            ext_gnt      = 1'b1;
            ext_rdata    = mem_rdata;
        end
    end

endmodule
